// File: rtl/interrupt_control.sv
// Z80-style interrupt control: I/R registers, IFF1/IFF2, interrupt mode, EI shadow,
// synchronised edge-latched NMI, HALT state and NMI/INT acceptance with service vector.
module interrupt_control #(
   parameter int unsigned EI_SHADOW       = 1,
   parameter int unsigned REFRESH_BITS    = 7,
   parameter int unsigned NMI_SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_wr,
   input  logic [7:0]  i_in,
   input  logic        r_wr,
   input  logic [7:0]  r_in,
   input  logic        refresh,
   input  logic        im_wr,
   input  logic [1:0]  im_in,
   input  logic        ei,
   input  logic        di,
   input  logic        retn,
   input  logic        halt_insn,
   input  logic        insn_done,
   input  logic        nmi_n,
   input  logic        int_n,
   input  logic [7:0]  ack_data,
   output logic [7:0]  reg_i,
   output logic [7:0]  reg_r,
   output logic [1:0]  im,
   output logic        iff1,
   output logic        iff2,
   output logic        ei_shadow,
   output logic        halted,
   output logic        nmi_pending,
   output logic        take_nmi,
   output logic        take_int,
   output logic [15:0] int_vector
);

   localparam int unsigned RMaskInt   = (1 << REFRESH_BITS) - 1;
   localparam logic [7:0]  RMask      = RMaskInt[7:0];
   localparam logic [2:0]  ShadowLoad = EI_SHADOW[2:0];

   logic [7:0]                 i_q, i_d;
   logic [7:0]                 r_q, r_d;
   logic [1:0]                 im_q, im_d;
   logic                       iff1_q, iff1_d;
   logic                       iff2_q, iff2_d;
   logic [2:0]                 shadow_q, shadow_d;
   logic                       halted_q, halted_d;
   logic                       nmi_pending_q, nmi_pending_d;
   logic                       last_nmi_q, last_nmi_d;
   logic [NMI_SYNC_STAGES-1:0] sync_q, sync_d;
   logic                       sync_prev_q, sync_prev_d;
   logic                       nmi_fall;
   logic                       blocked;
   logic [7:0]                 r_inc;

   always_comb begin
      blocked  = ei | di | retn;
      take_nmi = insn_done & nmi_pending_q & ~blocked;
      take_int = insn_done & ~take_nmi & ~blocked & iff1_q & ~int_n & (shadow_q == 3'd0);

      sync_d      = {sync_q[NMI_SYNC_STAGES-2:0], nmi_n};
      sync_prev_d = sync_q[NMI_SYNC_STAGES-1];
      nmi_fall    = sync_prev_q & ~sync_q[NMI_SYNC_STAGES-1];

      i_d = i_wr ? i_in : i_q;

      // Only the low REFRESH_BITS bits roll over; the upper bits are preserved.
      r_inc = r_q + 8'd1;
      if (r_wr)         r_d = r_in;
      else if (refresh) r_d = (r_q & ~RMask) | (r_inc & RMask);
      else              r_d = r_q;

      im_d = (im_wr && im_in != 2'd3) ? im_in : im_q;

      iff1_d     = iff1_q;
      iff2_d     = iff2_q;
      shadow_d   = shadow_q;
      last_nmi_d = last_nmi_q;
      if (di) begin
         iff1_d   = 1'b0;
         iff2_d   = 1'b0;
         shadow_d = 3'd0;
      end else if (ei) begin
         iff1_d   = 1'b1;
         iff2_d   = 1'b1;
         shadow_d = ShadowLoad;
      end else if (take_nmi) begin
         iff2_d     = iff1_q;
         iff1_d     = 1'b0;
         shadow_d   = 3'd0;
         last_nmi_d = 1'b1;
      end else if (take_int) begin
         iff1_d     = 1'b0;
         iff2_d     = 1'b0;
         last_nmi_d = 1'b0;
      end else if (retn) begin
         iff1_d = iff2_q;
      end else if (insn_done && shadow_q != 3'd0) begin
         shadow_d = shadow_q - 3'd1;
      end

      // A fresh edge in the same cycle as acceptance must not be lost.
      if (nmi_fall)      nmi_pending_d = 1'b1;
      else if (take_nmi) nmi_pending_d = 1'b0;
      else               nmi_pending_d = nmi_pending_q;

      if (take_nmi || take_int)       halted_d = 1'b0;
      else if (insn_done & halt_insn) halted_d = 1'b1;
      else                            halted_d = halted_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         i_q           <= 8'h00;
         r_q           <= 8'h00;
         im_q          <= 2'd0;
         iff1_q        <= 1'b0;
         iff2_q        <= 1'b0;
         shadow_q      <= 3'd0;
         halted_q      <= 1'b0;
         nmi_pending_q <= 1'b0;
         last_nmi_q    <= 1'b0;
         sync_q        <= '1;
         sync_prev_q   <= 1'b1;
      end else begin
         i_q           <= i_d;
         r_q           <= r_d;
         im_q          <= im_d;
         iff1_q        <= iff1_d;
         iff2_q        <= iff2_d;
         shadow_q      <= shadow_d;
         halted_q      <= halted_d;
         nmi_pending_q <= nmi_pending_d;
         last_nmi_q    <= last_nmi_d;
         sync_q        <= sync_d;
         sync_prev_q   <= sync_prev_d;
      end
   end

   always_comb begin
      if (last_nmi_q) begin
         int_vector = 16'h0066;
      end else begin
         case (im_q)
            2'd0:    int_vector = {8'h00, ack_data & 8'h38};
            2'd1:    int_vector = 16'h0038;
            2'd2:    int_vector = {i_q, ack_data[7:1], 1'b0};
            default: int_vector = 16'h0038;
         endcase
      end
   end

   assign reg_i       = i_q;
   assign reg_r       = r_q;
   assign im          = im_q;
   assign iff1        = iff1_q;
   assign iff2        = iff2_q;
   assign ei_shadow   = (shadow_q != 3'd0);
   assign halted      = halted_q;
   assign nmi_pending = nmi_pending_q;

endmodule
